// File: rtl/bomberman_pkg.sv
// Shared tile-map geometry, tile codes and the bomb controller state encoding.
package bomberman_pkg;

  localparam int unsigned MAP_COLS = 20;
  localparam int unsigned MAP_ROWS = 15;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned TILE_W   = 4;
  localparam int unsigned NBR_N    = 4;   // up, down, left, right

  localparam logic [TILE_W-1:0] TILE_FLOOR = 4'd0;
  localparam logic [TILE_W-1:0] TILE_WALL  = 4'd1;
  localparam logic [TILE_W-1:0] TILE_BRICK = 4'd2;

  localparam logic [ADDR_W-1:0] NO_TILE = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SCAN,
    CLEAR,
    BLAST
  } bomb_state_t;

  // Linear tile index for a (row, col) pair.
  function automatic logic [ADDR_W-1:0] tile_idx(input logic [4:0] row, input logic [4:0] col);
    return ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Frame tick generator: two-flop synchronizer on frame_clk followed by a
// rising-edge detect, giving a one-Clk-wide tick per frame.
//   Clk, Reset : system clock, async active-high reset
//   frame_clk  : vsync-rate level, treated as asynchronous data
//   tick       : one-cycle pulse per frame_clk rising edge
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  // [0],[1] synchronizer stages, [2] previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], frame_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bomb_ctrl.sv
// Single-bomb controller: places a bomb at the player's center tile, runs the
// fuse, scans the four neighbors through the map read port, erases bricks via
// the map write port and publishes the five lethal tiles during the blast.
//   Clk, Reset          : system clock, async active-high reset
//   frame_clk, allow    : frame-rate level and game-state code (0/1/31 = paused)
//   bomb_drop, userX/Y  : drop request level and player sprite top-left
//   map_addr / map_data : map read port (1-cycle read latency)
//   ram_en/addr/data    : map write port used to erase bricks
//   bombX/Y, bombXS/YS  : bomb sprite origin and size
//   bomb_active         : placement through end of blast
//   die_addr[0..4]      : lethal tiles center, up, down, left, right
module bomb_ctrl
  import bomberman_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned BLAST_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [4:0]  allow,
  input  logic        bomb_drop,
  input  logic [9:0]  userX,
  input  logic [9:0]  userY,
  output logic [9:0]  map_addr,
  input  logic [3:0]  map_data,
  output logic        ram_en,
  output logic [9:0]  ram_addr,
  output logic [3:0]  ram_data,
  output logic [9:0]  bombX,
  output logic [9:0]  bombY,
  output logic [9:0]  bombXS,
  output logic [9:0]  bombYS,
  output logic        bomb_active,
  output logic [9:0]  die_addr [5]
);

  localparam int unsigned FUSE_W  = $clog2(FUSE_FRAMES + 1);
  localparam int unsigned BLAST_W = $clog2(BLAST_FRAMES + 1);

  bomb_state_t        state_q, state_n;
  logic [FUSE_W-1:0]  fuse_q, fuse_n;
  logic [BLAST_W-1:0] blast_q, blast_n;
  logic [2:0]         scan_q, scan_n;
  logic [4:0]         row_q, row_n, col_q, col_n;
  logic [9:0]         tile_q, tile_n;
  logic [3:0]         code_q [NBR_N];
  logic [3:0]         code_n [NBR_N];
  logic [NBR_N-1:0]   pend_q, pend_n;
  logic               drop_q;

  logic [9:0] map_addr_n, ram_addr_n, bombX_n, bombY_n;
  logic       ram_en_n, bomb_active_n;
  logic [9:0] die_n [5];

  logic             tick, paused, tick_ok, drop_edge;
  logic [4:0]       row_c, col_c;
  logic [9:0]       nbr_addr [NBR_N];
  logic [NBR_N-1:0] nbr_ok, brick_now, issue_mask;
  logic [1:0]       sel, scan_next_k, scan_cap_k;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign bombXS = 10'd32;
  assign bombYS = 10'd32;

  assign paused    = (allow == 5'd0) || (allow == 5'd1) || (allow == 5'd31);
  assign tick_ok   = tick & ~paused;
  assign drop_edge = bomb_drop & ~drop_q;

  // Placement point is the sprite center (userX+10, userY+13).
  assign col_c = 5'((userX + 10'd10) >> 5);
  assign row_c = 5'((userY + 10'd13) >> 5);

  // Neighbor addresses and on-grid flags, order up, down, left, right.
  assign nbr_addr[0] = tile_q - 10'd20;
  assign nbr_addr[1] = tile_q + 10'd20;
  assign nbr_addr[2] = tile_q - 10'd1;
  assign nbr_addr[3] = tile_q + 10'd1;
  assign nbr_ok[0]   = (row_q != 5'd0);
  assign nbr_ok[1]   = (row_q != 5'(MAP_ROWS - 1));
  assign nbr_ok[2]   = (col_q != 5'd0);
  assign nbr_ok[3]   = (col_q != 5'(MAP_COLS - 1));

  assign scan_next_k = 2'(scan_q + 3'd1);
  assign scan_cap_k  = 2'(scan_q - 3'd1);

  // Capture of read data; off-grid neighbors are never read and count as wall.
  always_comb begin
    for (int k = 0; k < int'(NBR_N); k++) code_n[k] = code_q[k];
    if (state_q == SCAN && scan_q != 3'd0)
      code_n[scan_cap_k] = nbr_ok[scan_cap_k] ? map_data : TILE_WALL;
    for (int k = 0; k < int'(NBR_N); k++) brick_now[k] = (code_n[k] == TILE_BRICK);
  end

  // Lowest pending brick is erased first.
  always_comb begin
    issue_mask = (state_q == SCAN) ? brick_now : pend_q;
    sel        = 2'd0;
    for (int k = int'(NBR_N) - 1; k >= 0; k--)
      if (issue_mask[k]) sel = 2'(k);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n       = state_q;
    fuse_n        = fuse_q;
    blast_n       = blast_q;
    scan_n        = scan_q;
    row_n         = row_q;
    col_n         = col_q;
    tile_n        = tile_q;
    pend_n        = pend_q;
    map_addr_n    = map_addr;
    ram_en_n      = 1'b0;
    ram_addr_n    = ram_addr;
    bombX_n       = bombX;
    bombY_n       = bombY;
    bomb_active_n = bomb_active;
    for (int k = 0; k < 5; k++) die_n[k] = die_addr[k];

    unique case (state_q)
      IDLE: begin
        if (drop_edge && !paused) begin
          state_n       = ARMED;
          fuse_n        = FUSE_W'(FUSE_FRAMES);
          row_n         = row_c;
          col_n         = col_c;
          tile_n        = tile_idx(row_c, col_c);
          bombX_n       = {col_c, 5'd0};
          bombY_n       = {row_c, 5'd0};
          bomb_active_n = 1'b1;
        end
      end
      ARMED: begin
        if (tick_ok) begin
          if (fuse_q <= FUSE_W'(1)) begin
            state_n    = SCAN;
            fuse_n     = '0;
            scan_n     = 3'd0;
            map_addr_n = nbr_ok[0] ? nbr_addr[0] : tile_q;
          end else begin
            fuse_n = fuse_q - FUSE_W'(1);
          end
        end
      end
      SCAN: begin
        scan_n = scan_q + 3'd1;
        if (scan_q < 3'd3)
          map_addr_n = nbr_ok[scan_next_k] ? nbr_addr[scan_next_k] : tile_q;
        if (scan_q == 3'd4) begin
          state_n = CLEAR;
          scan_n  = 3'd0;
          pend_n  = '0;
          if (issue_mask != '0) begin
            ram_en_n   = 1'b1;
            ram_addr_n = nbr_addr[sel];
            pend_n     = issue_mask & ~(4'b0001 << sel);
          end
        end
      end
      CLEAR: begin
        if (issue_mask != '0) begin
          ram_en_n   = 1'b1;
          ram_addr_n = nbr_addr[sel];
          pend_n     = issue_mask & ~(4'b0001 << sel);
        end else begin
          state_n  = BLAST;
          blast_n  = BLAST_W'(BLAST_FRAMES);
          die_n[0] = tile_q;
          for (int k = 0; k < int'(NBR_N); k++)
            die_n[k+1] = (code_q[k] != TILE_WALL) ? nbr_addr[k] : NO_TILE;
        end
      end
      BLAST: begin
        if (tick_ok) begin
          if (blast_q <= BLAST_W'(1)) begin
            state_n       = IDLE;
            blast_n       = '0;
            bomb_active_n = 1'b0;
            for (int k = 0; k < 5; k++) die_n[k] = NO_TILE;
          end else begin
            blast_n = blast_q - BLAST_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      fuse_q      <= '0;
      blast_q     <= '0;
      scan_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      tile_q      <= '0;
      pend_q      <= '0;
      drop_q      <= 1'b0;
      map_addr    <= '0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      bombX       <= '0;
      bombY       <= '0;
      bomb_active <= 1'b0;
      for (int k = 0; k < int'(NBR_N); k++) code_q[k] <= TILE_FLOOR;
      for (int k = 0; k < 5; k++) die_addr[k] <= NO_TILE;
    end else begin
      state_q     <= state_n;
      fuse_q      <= fuse_n;
      blast_q     <= blast_n;
      scan_q      <= scan_n;
      row_q       <= row_n;
      col_q       <= col_n;
      tile_q      <= tile_n;
      pend_q      <= pend_n;
      drop_q      <= bomb_drop;
      map_addr    <= map_addr_n;
      ram_en      <= ram_en_n;
      ram_addr    <= ram_addr_n;
      ram_data    <= '0;
      bombX       <= bombX_n;
      bombY       <= bombY_n;
      bomb_active <= bomb_active_n;
      for (int k = 0; k < int'(NBR_N); k++) code_q[k] <= code_n[k];
      for (int k = 0; k < 5; k++) die_addr[k] <= die_n[k];
    end
  end

endmodule

// File: tb/tb_bomb_ctrl.sv
`timescale 1ns/1ps
module tb_bomb_ctrl;

  localparam logic [9:0] NT = 10'h3FF;
  localparam int K_PLACE = 0;
  localparam int K_WRITE = 1;
  localparam int K_BLAST = 2;
  localparam int K_END   = 3;
  localparam int K_RST   = 4;
  localparam int LIMIT   = 6000;

  typedef struct {
    int              kind;
    logic [4:0][9:0] v;
    int              ticks;
  } exp_t;

  logic       Clk, Reset, frame_clk, bomb_drop;
  logic [4:0] allow;
  logic [9:0] userX, userY, map_addr, ram_addr, bombX, bombY, bombXS, bombYS;
  logic [3:0] map_data, ram_data;
  logic       ram_en, bomb_active;
  logic [9:0] die_addr [5];

  logic [3:0] tmap [300];
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         rises = 0;
  int         bad_addr = 0;
  int         place_rise = 0;
  int         blast_rise = 0;
  logic       prev_active = 1'b0;
  logic [9:0] prev_die0 = NT;

  bomb_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .allow(allow),
    .bomb_drop(bomb_drop), .userX(userX), .userY(userY),
    .map_addr(map_addr), .map_data(map_data),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .bombX(bombX), .bombY(bombY), .bombXS(bombXS), .bombYS(bombYS),
    .bomb_active(bomb_active), .die_addr(die_addr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Frame level: 8 Clk high, 8 Clk low.
  initial begin
    frame_clk = 1'b0;
    forever begin
      repeat (8) @(posedge Clk);
      #1 frame_clk = ~frame_clk;
    end
  end
  always @(posedge frame_clk) rises++;

  // Map RAM read model, one cycle latency.
  always @(posedge Clk) map_data <= (map_addr < 10'd300) ? tmap[map_addr] : 4'd1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit pop(input int kind, output exp_t e);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event_kind: got unexpected event kind %0d expected no event", kind);
      return 1'b0;
    end
    e = q.pop_front();
    if (e.kind != kind) begin
      errors++;
      $display("FAIL event_kind: got kind %0d expected kind %0d", kind, e.kind);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: pops the next expected event whenever the DUT presents one.
  always @(negedge Clk) begin
    exp_t e;
    int   k;
    if (map_addr >= 10'd300) bad_addr++;
    if (ram_en) begin
      if (pop(K_WRITE, e)) begin
        check("ram_addr", 64'(ram_addr), 64'(e.v[0]));
        check("ram_data", 64'(ram_data), 64'd0);
      end
    end
    if (bomb_active && !prev_active) begin
      if (pop(K_PLACE, e)) begin
        check("bombX", 64'(bombX), 64'(e.v[0]));
        check("bombY", 64'(bombY), 64'(e.v[1]));
      end
      place_rise = rises;
    end
    if (die_addr[0] != NT && prev_die0 == NT) begin
      if (pop(K_BLAST, e)) begin
        for (int i = 0; i < 5; i++)
          check($sformatf("die_addr[%0d]", i), 64'(die_addr[i]), 64'(e.v[i]));
        check("fuse_ticks", 64'(rises - place_rise), 64'(e.ticks));
      end
      blast_rise = rises;
    end
    if (!bomb_active && prev_active) begin
      k = (q.size() != 0 && q[0].kind == K_RST) ? K_RST : K_END;
      if (pop(k, e)) begin
        check("end_die_all", {14'd0, die_addr[0], die_addr[1], die_addr[2], die_addr[3], die_addr[4]},
              {14'd0, NT, NT, NT, NT, NT});
        check("end_ram_en", 64'(ram_en), 64'd0);
        if (k == K_END) check("blast_ticks", 64'(rises - blast_rise), 64'(e.ticks));
      end
    end
    prev_active = bomb_active;
    prev_die0   = die_addr[0];
  end

  task automatic expect_ev(input int kind, input logic [9:0] a0, a1, a2, a3, a4, input int ticks);
    exp_t e;
    e.kind  = kind;
    e.v     = {a4, a3, a2, a1, a0};
    e.ticks = ticks;
    q.push_back(e);
  endtask

  // Drive a drop edge in the low half of a frame, well clear of any tick.
  task automatic drop(input logic [9:0] x, input logic [9:0] y, input bit hold);
    @(negedge frame_clk);
    repeat (3) @(posedge Clk);
    #1;
    userX     = x;
    userY     = y;
    bomb_drop = 1'b1;
    if (!hold) begin
      repeat (2) @(posedge Clk);
      #1 bomb_drop = 1'b0;
    end
  endtask

  task automatic set_allow(input logic [4:0] a);
    @(negedge frame_clk);
    repeat (3) @(posedge Clk);
    #1 allow = a;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q.size() != 0 || bomb_active) && n < LIMIT) begin
      @(posedge Clk);
      n++;
    end
    #1;
    check({"done_", name}, 64'(n < LIMIT), 64'd1);
  endtask

  task automatic floor_map();
    for (int i = 0; i < 300; i++) tmap[i] = 4'd0;
  endtask

  initial begin
    int n;
    int bad0;
    Reset = 1'b1; allow = 5'd5; bomb_drop = 1'b0; userX = '0; userY = '0;
    floor_map();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_bomb_active", 64'(bomb_active), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_data", 64'(ram_data), 64'd0);
    check("rst_map_addr", 64'(map_addr), 64'd0);
    check("rst_bombX", 64'(bombX), 64'd0);
    check("rst_bombY", 64'(bombY), 64'd0);
    check("rst_bombXS", 64'(bombXS), 64'd32);
    check("rst_bombYS", 64'(bombYS), 64'd32);
    check("rst_die_all", {14'd0, die_addr[0], die_addr[1], die_addr[2], die_addr[3], die_addr[4]},
          {14'd0, NT, NT, NT, NT, NT});
    @(negedge Clk) Reset = 1'b0;

    // Floor all around tile 123.
    expect_ev(K_PLACE, 10'd96, 10'd192, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd123, 10'd103, 10'd143, 10'd122, 10'd124, 120);
    expect_ev(K_END, 0, 0, 0, 0, 0, 30);
    drop(10'd100, 10'd200, 1'b0);
    wait_done("floor");

    // Brick above, wall to the right.
    tmap[103] = 4'd2;
    tmap[124] = 4'd1;
    expect_ev(K_PLACE, 10'd96, 10'd192, 0, 0, 0, 0);
    expect_ev(K_WRITE, 10'd103, 0, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd123, 10'd103, 10'd143, 10'd122, NT, 120);
    expect_ev(K_END, 0, 0, 0, 0, 0, 30);
    drop(10'd100, 10'd200, 1'b0);
    wait_done("brick");
    floor_map();

    // Drop edge while paused is ignored.
    set_allow(5'd31);
    drop(10'd100, 10'd200, 1'b0);
    repeat (3) @(posedge frame_clk);
    #1 check("paused_drop_ignored", 64'(bomb_active), 64'd0);
    set_allow(5'd5);
    repeat (2) @(posedge frame_clk);
    #1 check("unpause_no_bomb", 64'(bomb_active), 64'd0);

    // Pause 50 frames mid-fuse.
    expect_ev(K_PLACE, 10'd96, 10'd192, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd123, 10'd103, 10'd143, 10'd122, 10'd124, 170);
    expect_ev(K_END, 0, 0, 0, 0, 0, 30);
    drop(10'd100, 10'd200, 1'b0);
    repeat (40) @(posedge frame_clk);
    set_allow(5'd0);
    repeat (50) @(posedge frame_clk);
    set_allow(5'd5);
    wait_done("pause");

    // Hold bomb_drop through a full bomb: only one placement.
    expect_ev(K_PLACE, 10'd96, 10'd192, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd123, 10'd103, 10'd143, 10'd122, 10'd124, 120);
    expect_ev(K_END, 0, 0, 0, 0, 0, 30);
    drop(10'd100, 10'd200, 1'b1);
    wait_done("hold");
    repeat (5) @(posedge frame_clk);
    #1 check("hold_no_rebomb", 64'(bomb_active), 64'd0);
    @(negedge Clk) bomb_drop = 1'b0;
    repeat (4) @(posedge Clk);

    // Re-press places a second bomb; reset it mid-blast.
    expect_ev(K_PLACE, 10'd96, 10'd192, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd123, 10'd103, 10'd143, 10'd122, 10'd124, 120);
    expect_ev(K_RST, 0, 0, 0, 0, 0, 0);
    drop(10'd100, 10'd200, 1'b0);
    n = 0;
    while (die_addr[0] == NT && n < LIMIT) begin
      @(posedge Clk);
      n++;
    end
    check("second_bomb_blast", 64'(n < LIMIT), 64'd1);
    repeat (5) @(posedge frame_clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_events_drained", 64'(q.size()), 64'd0);

    // Corner tile 0: up/left off-grid and never read.
    bad0 = bad_addr;
    expect_ev(K_PLACE, 10'd0, 10'd0, 0, 0, 0, 0);
    expect_ev(K_BLAST, 10'd0, NT, 10'd20, NT, 10'd1, 120);
    expect_ev(K_END, 0, 0, 0, 0, 0, 30);
    drop(10'd0, 10'd0, 1'b0);
    wait_done("corner");
    check("offgrid_reads", 64'(bad_addr - bad0), 64'd0);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
